// File: rtl/mem_resp_pkg.sv
// Shared command and state encodings for the data memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    CmdHalt = 2'b00,
    CmdLoad = 2'b01,
    CmdDump = 2'b10,
    CmdRun  = 2'b11
  } host_cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDump,
    StRun
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: one synchronous write port, two asynchronous read ports.
module mem_array #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256,
  localparam int unsigned AddrBits = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AddrBits-1:0] waddr_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic [AddrBits-1:0] raddr_a_i,
  output logic [Width-1:0]    rdata_a_o,
  input  logic [AddrBits-1:0] raddr_b_i,
  output logic [Width-1:0]    rdata_b_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder with a host port that preloads/dumps memory while the CPU is held.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256,
  localparam int unsigned AddrBits = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    mem_addr_i,
  input  logic                write_mem_en_i,
  input  logic [Width-1:0]    write_mem_data_i,
  output logic [Width-1:0]    read_mem_data_o,
  output logic                cpu_hold_o,
  input  logic [1:0]          host_cmd_i,
  input  logic                host_cmd_valid_i,
  output logic                host_cmd_ready_o,
  input  logic [AddrBits-1:0] host_base_i,
  input  logic [AddrBits:0]   host_len_i,
  input  logic [Width-1:0]    host_wdata_i,
  input  logic                host_wvalid_i,
  output logic                host_wready_o,
  output logic [Width-1:0]    host_rdata_o,
  output logic                host_rvalid_o,
  input  logic                host_rready_i,
  output logic                busy_o,
  output logic                addr_err_o
);

  localparam logic [Width-1:0]  AddrLimit = Width'(Depth * 4);
  localparam logic [AddrBits:0] DepthLen  = (AddrBits + 1)'(Depth);
  localparam logic [AddrBits:0] OneLen    = (AddrBits + 1)'(1);

  state_e              state_q, state_d;
  logic [AddrBits-1:0] ptr_q, ptr_d;
  logic [AddrBits:0]   rem_q, rem_d;
  logic                rvalid_q, rvalid_d;
  logic [Width-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                cpu_hold_q, cmd_ready_q, wready_q, busy_q;

  host_cmd_e           cmd;
  logic                cmd_fire;
  logic                cpu_in_range;
  logic [AddrBits-1:0] cpu_idx, dump_raddr, waddr;
  logic [Width-1:0]    cpu_rdata, dump_rdata, wdata;
  logic                we;
  logic                unused_addr;

  function automatic logic [AddrBits-1:0] next_idx(input logic [AddrBits-1:0] idx);
    return (idx == AddrBits'(Depth - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign cmd          = host_cmd_e'(host_cmd_i);
  assign cmd_fire     = host_cmd_valid_i & cmd_ready_q;
  assign cpu_in_range = mem_addr_i < AddrLimit;
  assign cpu_idx      = mem_addr_i[AddrBits+1:2];
  assign unused_addr  = ^mem_addr_i[1:0];

  // Dump port looks one word ahead so the next beat is ready at the handshake edge.
  assign dump_raddr = (state_q == StDump) ? next_idx(ptr_q) : host_base_i;

  // Gated by reset so an aborting edge cannot commit a stray beat.
  assign we    = rst_ni & (((state_q == StLoad) & host_wvalid_i) |
                           ((state_q == StRun) & write_mem_en_i & cpu_in_range));
  assign waddr = (state_q == StLoad) ? ptr_q : cpu_idx;
  assign wdata = (state_q == StLoad) ? host_wdata_i : write_mem_data_i;

  mem_array #(
    .Width (Width),
    .Depth (Depth)
  ) u_mem (
    .clk_i     (clk_i),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (cpu_idx),
    .rdata_a_o (cpu_rdata),
    .raddr_b_i (dump_raddr),
    .rdata_b_o (dump_rdata)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          unique case (cmd)
            CmdLoad, CmdDump: begin
              if (cmd == CmdLoad) err_d = 1'b0;
              if (host_len_i > DepthLen) begin
                err_d = 1'b1;
              end else if (host_len_i != '0) begin
                state_d = (cmd == CmdLoad) ? StLoad : StDump;
                ptr_d   = host_base_i;
                rem_d   = host_len_i;
                if (cmd == CmdDump) begin
                  rvalid_d = 1'b1;
                  rdata_d  = dump_rdata;
                end
              end
            end
            CmdRun:  state_d = StRun;
            CmdHalt: ;
            default: ;
          endcase
        end
      end
      StLoad: begin
        if (host_wvalid_i) begin
          ptr_d = next_idx(ptr_q);
          rem_d = rem_q - OneLen;
          if (rem_q == OneLen) state_d = StIdle;
        end
      end
      StDump: begin
        if (rvalid_q && host_rready_i) begin
          if (rem_q > OneLen) begin
            ptr_d   = next_idx(ptr_q);
            rem_d   = rem_q - OneLen;
            rdata_d = dump_rdata;
          end else begin
            rvalid_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      StRun: begin
        if (!cpu_in_range) err_d = 1'b1;
        // Any accepted command halts the CPU; non-HALT payloads are dropped.
        if (cmd_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      rem_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cpu_hold_q  <= 1'b1;
      cmd_ready_q <= 1'b1;
      wready_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cpu_hold_q  <= (state_d != StRun);
      cmd_ready_q <= (state_d == StIdle) || (state_d == StRun);
      wready_q    <= (state_d == StLoad);
      busy_q      <= (state_d == StLoad) || (state_d == StDump);
    end
  end

  assign read_mem_data_o  = ((state_q == StRun) && cpu_in_range) ? cpu_rdata : '0;
  assign cpu_hold_o       = cpu_hold_q;
  assign host_cmd_ready_o = cmd_ready_q;
  assign host_wready_o    = wready_q;
  assign host_rdata_o     = rdata_q;
  assign host_rvalid_o    = rvalid_q;
  assign busy_o           = busy_q;
  assign addr_err_o       = err_q;

endmodule
